// File: rtl/des_dec_key_sched_if.sv
// Handshake bundle for the DES decryption key schedule: key input channel
// and subkey output channel, both valid/ready.
interface des_dec_key_sched_if;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_idx;
  logic        sk_last;

  modport slave (
    input  key_valid, key, sk_ready,
    output key_ready, sk_valid, subkey, sk_idx, sk_last
  );

  modport master (
    output key_valid, key, sk_ready,
    input  key_ready, sk_valid, subkey, sk_idx, sk_last
  );
endinterface

// File: rtl/des_dec_key_sched.sv
// Iterative DES decryption key schedule: accepts a 64-bit key and emits
// K16..K1 by right-rotating the C/D halves after each subkey handshake.
module des_dec_key_sched (
  input  logic                    clk,
  input  logic                    rst_n,
  des_dec_key_sched_if.slave      bus
);

  // DES bit numbers (1-based, bit 1 = MSB) for the two permuted choices.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state, state_next;
  logic [27:0] c_q, d_q;
  logic [3:0]  idx_q;
  logic [55:0] pc1_key;
  logic [55:0] cd;
  logic [47:0] pc2_out;
  logic [27:0] c_rot, d_rot;
  logic        rot_one;
  logic        load;
  logic        shift;

  assign cd = {c_q, d_q};

  always_comb begin
    pc1_key = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      pc1_key[6'(55 - i)] = bus.key[6'(64 - PC1[i])];
    end
  end

  always_comb begin
    pc2_out = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      pc2_out[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
  end

  // Rotation for the step from K(idx+1) to K(idx) undoes left shift s(idx+1).
  always_comb begin
    rot_one = (idx_q == 4'd15) || (idx_q == 4'd8) ||
              (idx_q == 4'd1)  || (idx_q == 4'd0);
    if (rot_one) begin
      c_rot = {c_q[0], c_q[27:1]};
      d_rot = {d_q[0], d_q[27:1]};
    end else begin
      c_rot = {c_q[1:0], c_q[27:2]};
      d_rot = {d_q[1:0], d_q[27:2]};
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.key_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.sk_ready) begin
          if (idx_q == 4'd0) begin
            state_next = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q   <= '0;
      d_q   <= '0;
      idx_q <= '0;
    end else if (load) begin
      c_q   <= pc1_key[55:28];
      d_q   <= pc1_key[27:0];
      idx_q <= 4'd15;
    end else if (shift) begin
      c_q   <= c_rot;
      d_q   <= d_rot;
      idx_q <= idx_q - 4'd1;
    end
  end

  assign bus.key_ready = (state == IDLE);
  assign bus.sk_valid  = (state == RUN);
  assign bus.subkey    = pc2_out;
  assign bus.sk_idx    = idx_q;
  assign bus.sk_last   = (state == RUN) && (idx_q == 4'd0);

endmodule

// File: tb/tb_des_dec_key_sched.sv
// Self-checking bench for des_dec_key_sched against a forward DES key
// schedule model (left shifts on bit-numbered vectors, reversed order).
module tb_des_dec_key_sched;

  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR_KEY = 64'h123457799BBCDFF0;
  localparam logic [47:0] K16_STD = 48'hCB3D8B0E17F5;
  localparam logic [47:0] K15_STD = 48'hBF918D3D3F0A;
  localparam logic [47:0] K1_STD  = 48'h1B02EFFC7072;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;

  // mk[r] holds forward round key K(r+1)
  logic [47:0] mk [16];

  des_dec_key_sched_if bus ();

  des_dec_key_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Forward schedule: C/D as DES-numbered vectors, left shifts per round.
  task automatic model_keys(input logic [63:0] k);
    logic [1:64] kb;
    logic [1:56] pc;
    logic [1:28] c, d;
    logic [1:56] cdr;
    logic [1:48] ks;
    int unsigned s;
    kb = k;
    for (int unsigned i = 0; i < 56; i++) pc[6'(i + 1)] = kb[7'(PC1[i])];
    c = pc[1:28];
    d = pc[29:56];
    for (int unsigned r = 1; r <= 16; r++) begin
      s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
      for (int unsigned j = 0; j < s; j++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cdr = {c, d};
      for (int unsigned j = 0; j < 48; j++) ks[6'(j + 1)] = cdr[6'(PC2[j])];
      mk[4'(r - 1)] = ks;
    end
  endtask

  // Present a key and return just after the accepting edge.
  task automatic send_key(input logic [63:0] k);
    int n;
    bus.key_valid = 1'b1;
    bus.key       = k;
    n = 0;
    while (!bus.key_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus.key_ready) begin
      tests++;
      fails++;
      $display("FAIL send_key_timeout key_ready=%b required 1", bus.key_ready);
    end
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    bus.sk_ready  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    tests++; if (bus.key_ready !== 1'b1) begin fails++; $display("FAIL reset_key_ready got %b required 1", bus.key_ready); end
    tests++; if (bus.sk_valid !== 1'b0) begin fails++; $display("FAIL reset_sk_valid got %b required 0", bus.sk_valid); end
    tests++; if (bus.subkey !== 48'h0) begin fails++; $display("FAIL reset_subkey got %h required 0", bus.subkey); end
    tests++; if (bus.sk_idx !== 4'd0) begin fails++; $display("FAIL reset_sk_idx got %0d required 0", bus.sk_idx); end
    tests++; if (bus.sk_last !== 1'b0) begin fails++; $display("FAIL reset_sk_last got %b required 0", bus.sk_last); end
  endtask

  task automatic test_standard();
    int n;
    model_keys(STD_KEY);
    bus.sk_ready = 1'b1;
    send_key(STD_KEY);
    n = 0;
    while (bus.sk_valid && n < 40) begin
      if (n == 0) begin
        tests++; if (bus.subkey !== K16_STD) begin fails++; $display("FAIL std_k16 got %h required %h", bus.subkey, K16_STD); end
      end
      if (n == 1) begin
        tests++; if (bus.subkey !== K15_STD) begin fails++; $display("FAIL std_k15 got %h required %h", bus.subkey, K15_STD); end
      end
      if (n == 15) begin
        tests++; if (bus.subkey !== K1_STD) begin fails++; $display("FAIL std_k1 got %h required %h", bus.subkey, K1_STD); end
      end
      if (n < 16) begin
        tests++; if (bus.subkey !== mk[4'(15 - n)]) begin fails++; $display("FAIL std_subkey n=%0d got %h required %h", n, bus.subkey, mk[4'(15 - n)]); end
        tests++; if (bus.sk_idx !== 4'(15 - n)) begin fails++; $display("FAIL std_sk_idx n=%0d got %0d required %0d", n, bus.sk_idx, 15 - n); end
        tests++; if (bus.sk_last !== (n == 15)) begin fails++; $display("FAIL std_sk_last n=%0d got %b required %b", n, bus.sk_last, n == 15); end
        tests++; if (bus.key_ready !== 1'b0) begin fails++; $display("FAIL std_key_ready_run n=%0d got %b required 0", n, bus.key_ready); end
      end
      step();
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL std_valid_count got %0d required 16", n); end
    tests++; if (bus.key_ready !== 1'b1) begin fails++; $display("FAIL std_key_ready_17th got %b required 1", bus.key_ready); end
    bus.sk_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int          n;
    int          guard;
    bit          stalled;
    bit          r;
    logic [47:0] psk;
    logic [3:0]  pidx;
    model_keys(STD_KEY);
    bus.sk_ready = 1'b0;
    send_key(STD_KEY);
    n = 0;
    guard = 0;
    stalled = 1'b0;
    psk = '0;
    pidx = '0;
    while (n < 16 && guard < 300) begin
      if (stalled) begin
        tests++; if (bus.subkey !== psk || bus.sk_idx !== pidx || bus.sk_valid !== 1'b1) begin
          fails++; $display("FAIL bp_stable got %h/%0d/%b required %h/%0d/1", bus.subkey, bus.sk_idx, bus.sk_valid, psk, pidx);
        end
      end
      if (!bus.sk_valid) begin
        tests++; fails++;
        $display("FAIL bp_valid_dropped n=%0d got 0 required 1", n);
        break;
      end
      r = 1'($urandom_range(0, 1));
      bus.sk_ready = r;
      if (r) begin
        tests++; if (bus.subkey !== mk[4'(15 - n)] || bus.sk_idx !== 4'(15 - n)) begin
          fails++; $display("FAIL bp_subkey n=%0d got %h/%0d required %h/%0d", n, bus.subkey, bus.sk_idx, mk[4'(15 - n)], 15 - n);
        end
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        psk  = bus.subkey;
        pidx = bus.sk_idx;
      end
      step();
      guard++;
    end
    bus.sk_ready = 1'b0;
    tests++; if (n != 16) begin fails++; $display("FAIL bp_count got %0d required 16", n); end
    tests++; if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0) begin
      fails++; $display("FAIL bp_idle got ready=%b valid=%b required 1/0", bus.key_ready, bus.sk_valid);
    end
  endtask

  task automatic test_parity();
    int n;
    model_keys(STD_KEY);
    bus.sk_ready = 1'b1;
    send_key(PAR_KEY);
    tests++; if (bus.subkey !== K16_STD) begin fails++; $display("FAIL par_k16 got %h required %h", bus.subkey, K16_STD); end
    n = 0;
    while (bus.sk_valid && n < 40) begin
      if (n < 16) begin
        tests++; if (bus.subkey !== mk[4'(15 - n)]) begin fails++; $display("FAIL par_subkey n=%0d got %h required %h", n, bus.subkey, mk[4'(15 - n)]); end
      end
      step();
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL par_count got %0d required 16", n); end
    send_key(64'h0);
    n = 0;
    while (bus.sk_valid && n < 40) begin
      tests++; if (bus.subkey !== 48'h0) begin fails++; $display("FAIL zero_subkey n=%0d got %h required 0", n, bus.subkey); end
      step();
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL zero_count got %0d required 16", n); end
    bus.sk_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    bus.sk_ready = 1'b1;
    send_key(STD_KEY);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.sk_valid !== 1'b0 || bus.sk_last !== 1'b0 || bus.key_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset_ctrl got valid=%b last=%b ready=%b required 0/0/1", bus.sk_valid, bus.sk_last, bus.key_ready);
    end
    tests++; if (bus.subkey !== 48'h0 || bus.sk_idx !== 4'd0) begin
      fails++; $display("FAIL mid_reset_data got %h/%0d required 0/0", bus.subkey, bus.sk_idx);
    end
    step();
    rst_n = 1'b1;
    step();
    tests++; if (bus.sk_valid !== 1'b0) begin fails++; $display("FAIL mid_after_release got valid=%b required 0", bus.sk_valid); end
    send_key(STD_KEY);
    tests++; if (bus.subkey !== K16_STD || bus.sk_idx !== 4'd15) begin
      fails++; $display("FAIL mid_fresh_k16 got %h/%0d required %h/15", bus.subkey, bus.sk_idx, K16_STD);
    end
    n = 0;
    while (bus.sk_valid && n < 40) begin
      step();
      n++;
    end
    tests++; if (n != 16) begin fails++; $display("FAIL mid_fresh_count got %0d required 16", n); end
    bus.sk_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [63:0] k1, k2;
    int          n;
    int          acc;
    bus.sk_ready = 1'b1;
    k1 = {$urandom, $urandom};
    model_keys(k1);
    send_key(k1);
    for (int it = 0; it < 3; it++) begin
      acc = cyc;
      k2 = {$urandom, $urandom};
      bus.key_valid = 1'b1;
      bus.key       = k2;
      n = 0;
      while (bus.sk_valid && n < 40) begin
        if (n < 16) begin
          tests++; if (bus.subkey !== mk[4'(15 - n)] || bus.key_ready !== 1'b0) begin
            fails++; $display("FAIL b2b_run it=%0d n=%0d got %h ready=%b required %h ready=0", it, n, bus.subkey, bus.key_ready, mk[4'(15 - n)]);
          end
        end
        step();
        n++;
      end
      tests++; if (n != 16 || (cyc - acc) != 16) begin
        fails++; $display("FAIL b2b_len it=%0d got %0d/%0d required 16/16", it, n, cyc - acc);
      end
      tests++; if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0) begin
        fails++; $display("FAIL b2b_gap it=%0d got ready=%b valid=%b required 1/0", it, bus.key_ready, bus.sk_valid);
      end
      step();
      bus.key_valid = 1'b0;
      model_keys(k2);
      tests++; if (bus.sk_valid !== 1'b1 || bus.sk_idx !== 4'd15 || bus.subkey !== mk[15]) begin
        fails++; $display("FAIL b2b_second_k16 it=%0d got %b/%0d/%h required 1/15/%h", it, bus.sk_valid, bus.sk_idx, bus.subkey, mk[15]);
      end
    end
    n = 0;
    while (bus.sk_valid && n < 40) begin
      step();
      n++;
    end
    bus.sk_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    test_reset();
    test_standard();
    test_backpressure();
    test_parity();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_dec_key_sched.md
# des_dec_key_sched

Iterative DES decryption key schedule. Accepts one 64-bit DES key over a valid/ready handshake and emits the sixteen 48-bit round subkeys in decryption order, K16 first and K1 last, one per accepted output handshake. It sits beside the pipelined DES datapath and feeds the round stages on the decrypt side. It derives each subkey by right-rotating the C/D halves, so the datapath needs no stored table of subkeys.

## Interface
- No parameters. Widths are fixed by DES.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key_valid  in  1  key[63:0] is valid.
- key_ready  out  1  block can accept a key; high only in IDLE.
- key  in  64  DES key. DES bit 1 is key[63] and DES bit 64 is key[0]. Parity bits (DES bits 8, 16, …, 64) are ignored.
- sk_valid  out  1  subkey holds a valid subkey.
- sk_ready  in  1  consumer accepts the subkey.
- subkey  out  48  current subkey. DES bit 1 is subkey[47].
- sk_idx  out  4  round number minus 1 of the presented subkey: 15 for K16, down to 0 for K1.
- sk_last  out  1  high together with sk_valid while K1 is presented.

## Operation
- Registers:
  - C[27:0] and D[27:0], the key halves.
  - idx[3:0].
  - state, one of {IDLE, RUN}.
- Output derivation:
  - subkey = PC-2(C,D), pure wiring from registers.
  - sk_idx = idx.
  - sk_valid = (state==RUN).
  - sk_last = sk_valid && idx==0.
  - key_ready = (state==IDLE).
- IDLE:
  - On key_valid && key_ready: {C,D} <= PC-1(key), idx <= 15, go to RUN.
  - Otherwise hold.
- RUN:
  - Subkey presented: PC-2(C,D) is K(idx+1).
  - On sk_valid && sk_ready with idx != 0: rotate C and D right by s(idx+1), then idx <= idx-1. s(r) = 1 for r ∈ {1,2,9,16} and 2 otherwise.
  - On sk_valid && sk_ready with idx == 0: go to IDLE. C, D and idx hold their values.
  - Without sk_ready: C, D, idx and all outputs hold stable (AXI-style; no retraction).
- The first subkey needs no rotation, because C16 = C0 and D16 = D0 (28 total left shifts). The right-rotation sequence after each emit is 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for K16…K2.
- key_valid while in RUN is ignored, because key_ready is low. No key is ever dropped once accepted.

## Timing
- Reset (asynchronous, rst_n low):
  - state = IDLE, C = D = 0, idx = 0.
  - Hence sk_valid = 0, sk_last = 0, subkey = 0, sk_idx = 0, key_ready = 1.
- Key-accept latency: key accepted at edge N puts K16 on subkey with sk_valid=1 in the cycle after edge N.
- Throughput with sk_ready held high: 16 consecutive subkey cycles, then 1 IDLE cycle with key_ready=1.
  - The next key can be accepted at the 17th edge after the previous accept.
  - Best case is one key per 17 cycles.
- No combinational path from any input to any output.
- Reset mid-RUN: the sequence aborts immediately, outputs take their reset values, and no further subkeys are emitted for the aborted key.
- Simultaneous key_valid and the final sk handshake: the key is not accepted in that cycle because key_ready is still low. It is accepted on the following edge if still valid.

## Test plan
- Reset defaults: hold rst_n low, then release. Required: key_ready=1, sk_valid=0, subkey=0, sk_idx=0, sk_last=0.
- Standard vector: key 0x133457799BBCDFF1 with sk_ready=1.
  - Required: K16=0xCB3D8B0E17F5 with sk_idx=15 one cycle after accept.
  - Then K15=0xBF918D3D3F0A.
  - Last, K1=0x1B02EFFC7072 with sk_idx=0 and sk_last=1.
  - Exactly 16 sk_valid cycles in total, and key_ready high on the 17th cycle.
- Backpressure: same key with sk_ready toggled pseudo-randomly. Required: identical 16-subkey sequence, and subkey/sk_idx stable whenever sk_valid && !sk_ready.
- Parity independence: key 0x123457799BBCDFF0, which is 0x133457799BBCDFF1 with parity bits altered. Required: same 16 subkeys as the standard vector. Also, key 0 gives all 16 subkeys = 0.
- Reset mid-run: assert rst_n low after 5 subkeys, then release. Required: reset values immediately, then a fresh key 0x133457799BBCDFF1 produces K16=0xCB3D8B0E17F5 first.
- Back-to-back keys: key_valid held high with a second key during RUN. Required: second key accepted only after sk_last handshake plus one cycle, and its K16 is correct per a reference model.
